// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the seven-segment scan controller
//   SEG_OFF      all segments dark (active-low pattern)
//   SEG_A..SEG_G segment bit positions in the a..g vector
//   SEG_TABLE    active-high a..g pattern for each hex nibble
//   load_state_t load port FSM states
package seg_scan_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef enum logic {EMPTY, PENDING} load_state_t;
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to active-high a..g segment pattern
//   nibble  in  4  hex value
//   seg     out 7  segments a..g on bits 0..6, active-high
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl: tear-free multiplexed driver for common-anode hex digits
//   clk, rst_n        clock, asynchronous active-low reset
//   load_valid/ready  host load handshake; load_data nibble 0 = rightmost, load_dp active-high
//   blank             turns every anode off without stopping the scan
//   an_n, seg_n, dp_n active-low display pins, registered
//   frame_tick        one-cycle pulse after each scan wrap
//   Macro LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown)
module seven_segment_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp, supp;
    load_state_t             state, state_nxt;
    logic                    tick, wrap, an_off;
    logic [6:0]              seg_on;

    assign tick       = div_cnt == DIV_W'(REFRESH_DIV - 1);
    assign wrap       = tick && digit_idx == IDX_W'(NUM_DIGITS - 1);
    assign load_ready = state == EMPTY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) digit_idx <= wrap ? '0 : digit_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == EMPTY) ? (load_valid ? PENDING : EMPTY) : (wrap ? EMPTY : PENDING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            state <= state_nxt;
            if (load_ready && load_valid) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
            end
            // commit only at frame wrap so a frame never mixes old and new digits
            if (state == PENDING && wrap) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // a digit is blank when it and every higher nibble are zero
    always_comb begin
        supp = '0;
        for (int i = 1; i < NUM_DIGITS; i++) supp[i] = (disp_data >> (4 * i)) == '0;
    end
`else
    assign supp = '0;
`endif

    // first cycle of each slot is dark to stop ghosting between digits
    assign an_off = blank || div_cnt == '0 || supp[digit_idx];

    seg_hex_decoder u_dec (
        .nibble (disp_data[4*digit_idx +: 4]),
        .seg    (seg_on)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_off ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
            seg_n      <= an_off ? SEG_OFF : ~seg_on;
            dp_n       <= an_off || !disp_dp[digit_idx];
            frame_tick <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb_seven_segment_scan_ctrl: table, directed and random checks against a cycle-count model
module tb_seven_segment_scan_ctrl;
    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 0, rst_n = 0, load_valid = 0, blank = 0;
    logic        load_ready, dp_n, frame_tick;
    logic [15:0] load_data = 0;
    logic [3:0]  load_dp = 0, an_n;
    logic [6:0]  seg_n;

    seven_segment_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DIV_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .blank(blank), .an_n(an_n),
        .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // active-low glyphs for 0..F
    logic [6:0] seg_low [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_pass = 0, n_chk = 0;
    int m_c = 0;
    logic [15:0] m_disp = 0, m_pend = 0;
    logic [3:0]  m_dpr = 0, m_pdp = 0;
    logic        m_pv = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [6:0]  seg0;
        logic        dp0;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic supp(int d);
`ifdef LEADING_ZERO_BLANK_EN
        return d != 0 && (m_disp >> (4 * d)) == 0;
`else
        return d < 0;
`endif
    endfunction

    // one clock: predict from pre-edge state, update model, compare on the falling edge
    task automatic cyc();
        int dig;
        logic off, e_ft, lv;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        dig   = (m_c / R) % N;
        off   = blank || (m_c % R == 0) || supp(dig);
        e_an  = off ? 4'hF : ~(4'b1 << dig);
        e_seg = off ? 7'h7F : seg_low[m_disp[dig*4 +: 4]];
        e_dp  = off || !m_dpr[dig];
        e_ft  = (m_c % (R * N)) == R * N - 1;
        lv    = load_valid;
        @(posedge clk);
        if (m_pv && e_ft) begin
            m_disp = m_pend; m_dpr = m_pdp; m_pv = 0;
        end else if (!m_pv && lv) begin
            m_pend = load_data; m_pdp = load_dp; m_pv = 1;
        end
        m_c++;
        @(negedge clk);
        chk("an_n", an_n, e_an);
        chk("seg_n", seg_n, e_seg);
        chk("dp_n", dp_n, e_dp);
        chk("frame_tick", frame_tick, e_ft);
        chk("load_ready", load_ready, !m_pv);
    endtask

    task automatic model_reset();
        m_c = 0; m_disp = 0; m_pend = 0; m_dpr = 0; m_pdp = 0; m_pv = 0;
    endtask

    initial begin
        bit found;
        vecs[0] = '{16'h1234, 4'b0000, 7'h19, 1'b1};
        vecs[1] = '{16'h8888, 4'b0100, 7'h00, 1'b1};
        vecs[2] = '{16'hABCD, 4'b0001, 7'h21, 1'b0};
        vecs[3] = '{16'h0070, 4'b0000, 7'h40, 1'b1};
        vecs[4] = '{16'h0000, 4'b1111, 7'h40, 1'b0};
        vecs[5] = '{16'hFFFF, 4'b0000, 7'h0E, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst an_n", an_n, 4'hF);
        chk("rst seg_n", seg_n, 7'h7F);
        chk("rst dp_n", dp_n, 1);
        chk("rst frame_tick", frame_tick, 0);
        chk("rst load_ready", load_ready, 1);
        rst_n = 1;
        model_reset();

        foreach (vecs[i]) begin
            load_valid = 1; load_data = vecs[i].data; load_dp = vecs[i].dp;
            cyc();
            load_valid = 0;
            repeat (2 * R * N + R) cyc();
            found = 0;
            for (int k = 0; k < 2 * R * N && !found; k++) begin
                cyc();
                found = an_n == 4'b1110;
            end
            chk("digit0 found", found, 1);
            chk("digit0 seg_n", seg_n, vecs[i].seg0);
            chk("digit0 dp_n", dp_n, vecs[i].dp0);
        end

        load_valid = 1; load_data = 16'h1111; load_dp = 0;
        cyc();
        load_data = 16'h2222;
        repeat (2 * R * N) cyc();
        load_valid = 0;
        repeat (2 * R * N) cyc();
        chk("disp 2222 digit", m_disp, 16'h2222);

        blank = 1;
        repeat (10) cyc();
        blank = 0;
        repeat (R * N) cyc();

        found = 0;
        for (int k = 0; k < R * N && !found; k++) begin
            cyc();
            found = an_n != 4'hF;
        end
        chk("lit before reset", found, 1);
        #2 rst_n = 0;
        #1;
        chk("async an_n", an_n, 4'hF);
        chk("async seg_n", seg_n, 7'h7F);
        chk("async dp_n", dp_n, 1);
        chk("async load_ready", load_ready, 1);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        repeat (R * N + 2) cyc();

        for (int k = 0; k < 400; k++) begin
            load_valid = $urandom_range(0, 3) == 0;
            load_data  = 16'($urandom);
            load_dp    = 4'($urandom);
            blank      = $urandom_range(0, 7) == 0;
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
